// File: rtl/baud_tick_generator.sv
// ---------------------------------------------------------------------------
// baud_tick_generator
//
// Runtime-programmable oversample / baud tick generator shared by the UART
// transmit and receive paths.
//
//   os_tick   : one-cycle pulse every (div_q + 1) enabled clock cycles
//               (plus one extra cycle after a fractional carry, see below).
//   mid_tick  : coincides with the os_tick on which the per-bit oversample
//               count is OVERSAMPLE/2-1; the receiver samples data here.
//   baud_tick : coincides with the os_tick on which the per-bit oversample
//               count is OVERSAMPLE-1; the transmitter shifts here.
//
// Optional feature (compile-time macro BAUD_FRAC_EN):
//   Adds the frac_in port plus a FRAC_WIDTH-bit phase accumulator. At every
//   os period end the accumulator adds frac_q; a carry-out stretches the next
//   os period by one cycle, giving a mean period of
//   div_q + 1 + frac_q / 2**FRAC_WIDTH. Without the macro the period is
//   exactly div_q + 1 and frac_in does not exist.
//
// Parameters
//   DIV_WIDTH   : width of the integer divisor and the cycle counter
//   DEFAULT_DIV : divisor loaded by reset
//   OVERSAMPLE  : os_ticks per bit, even, 2..256
//   FRAC_WIDTH  : fractional divisor width (used with BAUD_FRAC_EN only)
//
// Ports
//   CLK       in   clock, everything on the rising edge
//   RST       in   synchronous active-high reset, overrides all inputs
//   enable    in   1 = count, 0 = freeze counters and force ticks low
//   clear     in   restart bit phase (counters zeroed, divisor kept),
//                  acts regardless of enable
//   div_wr    in   load div_in (and frac_in) into the divisor registers
//   div_in    in   new integer divisor
//   frac_in   in   new fractional divisor (BAUD_FRAC_EN builds only)
//   os_tick   out  registered oversample tick
//   baud_tick out  registered bit strobe
//   mid_tick  out  registered mid-bit sample strobe
//   div_q     out  currently active integer divisor
//
// Handshake note: this block has no valid/ready interface. Every input is a
// level sampled on each rising edge; every output is a registered level or a
// one-cycle pulse that is valid for exactly the cycle it is high.
// ---------------------------------------------------------------------------
module baud_tick_generator #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 5,
  parameter int OVERSAMPLE  = 16,
  parameter int FRAC_WIDTH  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_in,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_WIDTH-1:0] frac_in,
`endif
  output logic                 os_tick,
  output logic                 baud_tick,
  output logic                 mid_tick,
  output logic [DIV_WIDTH-1:0] div_q
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // -------------------------------------------------------------------------
  if (OVERSAMPLE < 2 || OVERSAMPLE > 256 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("baud_tick_generator: OVERSAMPLE must be even and in 2..256");
  end
  if (FRAC_WIDTH < 1 || FRAC_WIDTH > 16) begin : g_bad_frac
    $error("baud_tick_generator: FRAC_WIDTH must be in 1..16");
  end
  if (DIV_WIDTH < 1 || DIV_WIDTH > 31) begin : g_bad_div
    $error("baud_tick_generator: DIV_WIDTH must be in 1..31");
  end

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  // cyc_cnt is one bit wider than the divisor: a fractional carry lets the
  // compare value reach div_q + 1, which must not wrap for div_q = all-ones.
  logic [DIV_WIDTH:0]  cyc_cnt;
  logic [OS_W-1:0]     os_cnt;
  logic                carry_pend;

  // -------------------------------------------------------------------------
  // Period-end decode
  // -------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] div_sel;
  logic [DIV_WIDTH:0]   limit;
  logic                 period_end;
  logic                 wr_trunc;
  logic                 fire;

  always_comb begin
    div_sel    = div_q;
    limit      = '0;
    period_end = 1'b0;
    wr_trunc   = 1'b0;
    fire       = 1'b0;

    // A write takes effect on its own cycle: the count already compares
    // against the incoming divisor so it can never run past the new limit.
    if (div_wr) begin
      div_sel = div_in;
    end

    limit      = {1'b0, div_sel} + {{DIV_WIDTH{1'b0}}, carry_pend};
    period_end = (cyc_cnt == limit);

    // The current period has already gone past the new divisor: restart the
    // period from zero without a tick instead of counting up to the wrap.
    wr_trunc = div_wr && (cyc_cnt > {1'b0, div_in});

    fire = enable && !wr_trunc && period_end;
  end

  // -------------------------------------------------------------------------
  // Cycle counter, oversample counter and registered ticks
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc_cnt   <= '0;
      os_cnt    <= '0;
      div_q     <= DIV_RST;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      mid_tick  <= 1'b0;
    end else if (clear) begin
      // Re-phase for an RX start bit; a simultaneous write still lands.
      cyc_cnt   <= '0;
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      mid_tick  <= 1'b0;
      if (div_wr) begin
        div_q <= div_in;
      end
    end else begin
      if (div_wr) begin
        div_q <= div_in;
      end

      if (wr_trunc) begin
        cyc_cnt <= '0;
      end else if (enable) begin
        if (period_end) begin
          cyc_cnt <= '0;
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end

      // Ticks are decoded from os_cnt before it advances, so mid/baud land
      // on the same cycle as the os_tick that completes them.
      os_tick   <= fire;
      baud_tick <= fire && (os_cnt == OS_LAST);
      mid_tick  <= fire && (os_cnt == OS_MID);

      if (fire) begin
        if (os_cnt == OS_LAST) begin
          os_cnt <= '0;
        end else begin
          os_cnt <= os_cnt + 1'b1;
        end
      end
    end
  end

`ifdef BAUD_FRAC_EN
  // -------------------------------------------------------------------------
  // Fractional phase accumulator
  // -------------------------------------------------------------------------
  logic [FRAC_WIDTH-1:0] frac_q;
  logic [FRAC_WIDTH-1:0] frac_acc;
  logic [FRAC_WIDTH:0]   frac_sum;

  always_comb begin
    frac_sum = {1'b0, frac_acc} + {1'b0, frac_q};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      frac_q     <= '0;
      frac_acc   <= '0;
      carry_pend <= 1'b0;
    end else if (clear) begin
      frac_acc   <= '0;
      carry_pend <= 1'b0;
      if (div_wr) begin
        frac_q <= frac_in;
      end
    end else begin
      if (div_wr) begin
        frac_q <= frac_in;
      end
      // The carry of this period end stretches the following period only;
      // it is replaced at the next period end.
      if (fire) begin
        frac_acc   <= frac_sum[FRAC_WIDTH-1:0];
        carry_pend <= frac_sum[FRAC_WIDTH];
      end
    end
  end
`else
  // Integer-only build: the period is always exactly div_q + 1.
  assign carry_pend = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_generator.sv
// ---------------------------------------------------------------------------
// tb_baud_tick_generator
//
// Directed scenarios (reset timing, div=0, enable freeze, clear re-phase,
// write+clear, reset mid-count, optional fractional divisor) followed by a
// randomized run. A cycle-level reference model, written in terms of
// "cycles elapsed in the current oversample period" and "os ticks seen in the
// current bit", predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_baud_tick_generator;

  localparam int DW  = 16;
  localparam int OS  = 16;
  localparam int FW  = 4;
  localparam int DEF = 5;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          div_wr = 1'b0;
  logic [DW-1:0] div_in = '0;
  logic [FW-1:0] frac_in = '0;
  logic          os_tick, baud_tick, mid_tick;
  logic [DW-1:0] div_q;

  always #5 clk = ~clk;

  baud_tick_generator #(
    .DIV_WIDTH(DW), .DEFAULT_DIV(DEF), .OVERSAMPLE(OS), .FRAC_WIDTH(FW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .enable(enable),
    .clear(clear),
    .div_wr(div_wr),
    .div_in(div_in),
`ifdef BAUD_FRAC_EN
    .frac_in(frac_in),
`endif
    .os_tick(os_tick),
    .baud_tick(baud_tick),
    .mid_tick(mid_tick),
    .div_q(div_q)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_div, m_frac, m_el, m_os, m_acc, m_carry;
  bit m_ost, m_bt, m_mt;

  task automatic model_reset();
    m_div = DEF; m_frac = 0; m_el = 0; m_os = 0; m_acc = 0; m_carry = 0;
    m_ost = 0; m_bt = 0; m_mt = 0;
  endtask

  task automatic model_update();
    int lim;
    if (rst) begin
      model_reset();
    end else if (clear) begin
      m_el = 0; m_os = 0; m_acc = 0; m_carry = 0;
      m_ost = 0; m_bt = 0; m_mt = 0;
      if (div_wr) begin
        m_div = int'(div_in);
`ifdef BAUD_FRAC_EN
        m_frac = int'(frac_in);
`endif
      end
    end else begin
      lim = (div_wr ? int'(div_in) : m_div) + m_carry;
      m_ost = 0; m_bt = 0; m_mt = 0;
      if (div_wr && m_el > int'(div_in)) begin
        m_el = 0;
      end else if (enable) begin
        if (m_el == lim) begin
          m_ost = 1;
          m_mt  = (m_os == OS / 2 - 1);
          m_bt  = (m_os == OS - 1);
          m_os  = (m_os + 1) % OS;
          m_el  = 0;
`ifdef BAUD_FRAC_EN
          m_acc   = m_acc + m_frac;
          m_carry = m_acc / (1 << FW);
          m_acc   = m_acc % (1 << FW);
`endif
        end else begin
          m_el++;
        end
      end
      if (div_wr) begin
        m_div = int'(div_in);
`ifdef BAUD_FRAC_EN
        m_frac = int'(frac_in);
`endif
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model advances on the edge, outputs are compared 1 time unit
  // later, and the caller drives the next inputs from there.
  task automatic step();
    @(posedge clk);
    model_update();
    exp_q.push_back({29'd0, m_ost, m_mt, m_bt});
    exp_q.push_back(32'(m_div));
    #1;
    check("os_tick",   {31'd0, os_tick},   {31'd0, exp_q[0][2]});
    check("mid_tick",  {31'd0, mid_tick},  {31'd0, exp_q[0][1]});
    check("baud_tick", {31'd0, baud_tick}, {31'd0, exp_q[0][0]});
    check("div_q",     32'(div_q),         exp_q[1]);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
  endtask

  function automatic logic tick_sel(input int sel);
    case (sel)
      0:       return os_tick;
      1:       return mid_tick;
      default: return baud_tick;
    endcase
  endfunction

  // Steps until the selected tick is seen; n = number of steps taken.
  task automatic wait_tick(input int sel, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_sel(sel) && n < budget);
    if (!tick_sel(sel)) begin
      check("wait_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic write_div(input int d, input int f, input bit with_clear);
    div_wr = 1'b1; div_in = DW'(d); frac_in = FW'(f); clear = with_clear;
    step();
    div_wr = 1'b0; clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, t;
    model_reset();

    // Reset with enable already high: everything quiet, default divisor.
    rst = 1'b1; enable = 1'b1;
    step(); step();
    check("rst_os",  {31'd0, os_tick}, 32'd0);
    check("rst_div", 32'(div_q), 32'(DEF));
    rst = 1'b0;

    // Scenario 1: os at 6, mid at 48, baud at 96 then every 96.
    wait_tick(0, 200, n); t = n;
    check("first_os_cycle", 32'(t), 32'd6);
    wait_tick(1, 200, n); t += n;
    check("first_mid_cycle", 32'(t), 32'd48);
    wait_tick(2, 200, n); t += n;
    check("first_baud_cycle", 32'(t), 32'd96);
    wait_tick(2, 200, n);
    check("baud_period_div5", 32'(n), 32'd96);

    // Scenario 2: div 0 -> baud every 16; then div 2 -> os period 3.
    write_div(0, 0, 1'b0);
    wait_tick(2, 100, n);
    wait_tick(2, 100, n);
    check("baud_period_div0", 32'(n), 32'd16);
    write_div(2, 0, 1'b0);
    wait_tick(0, 20, n);
    wait_tick(0, 20, n);
    check("os_period_div2", 32'(n), 32'd3);

    // Scenario 3: 10 disabled cycles mid-bit delay baud by exactly 10.
    wait_tick(2, 200, n);
    repeat (20) step();
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    wait_tick(2, 200, n);
    check("baud_gap_with_freeze", 32'(n + 30), 32'd58);

    // Scenario 4: clear at a random phase -> mid exactly 48 cycles later.
    write_div(5, 0, 1'b0);
    repeat ($urandom_range(0, 40)) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    wait_tick(1, 200, n);
    check("mid_after_clear", 32'(n), 32'd48);

    // Scenario 5: write(3)+clear with cyc_cnt=5, then reset mid-count.
    wait_tick(0, 20, n);
    repeat (5) step();
    write_div(3, 0, 1'b1);
    check("div_after_wr_clear", 32'(div_q), 32'd3);
    wait_tick(0, 20, n);
    check("os_after_wr_clear", 32'(n), 32'd4);
    repeat (2) step();
    rst = 1'b1; div_wr = 1'b1; div_in = DW'(9);
    step();
    rst = 1'b0; div_wr = 1'b0;
    check("rst_mid_os",   {31'd0, os_tick},   32'd0);
    check("rst_mid_baud", {31'd0, baud_tick}, 32'd0);
    check("rst_mid_div",  32'(div_q), 32'(DEF));

`ifdef BAUD_FRAC_EN
    // Scenario 6: div 5 + 8/16 -> periods alternate 6/7, 32 span 208.
    write_div(5, 8, 1'b1);
    wait_tick(0, 20, n);
    t = 0;
    for (int k = 0; k < 32; k++) begin
      wait_tick(0, 20, n);
      t += n;
    end
    check("frac_span_32", 32'(t), 32'd208);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      enable  = ($urandom_range(0, 9) != 0);
      clear   = ($urandom_range(0, 59) == 0);
      div_wr  = ($urandom_range(0, 49) == 0);
      div_in  = DW'($urandom_range(0, 9));
      frac_in = FW'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
